// File: rtl/simon_pattern_sequencer.sv
// Colour-sequence store for the Simon game: playback, guess checking and rewind.
// Shift-register datapath with a shadow copy so a pattern can be replayed without reloading.
module simon_pattern_sequencer #(
  parameter int COLOR_W = 2,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       load_p,
  input  logic [COLOR_W*MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]           length,
  input  logic                       rewind,
  input  logic                       next,
  input  logic                       guess_valid,
  input  logic [COLOR_W-1:0]         guess,
  output logic [COLOR_W-1:0]         color,
  output logic                       color_valid,
  output logic [LEN_W-1:0]           remaining,
  output logic                       done,
  output logic                       fail,
  output logic                       match,
  output logic                       mismatch
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, FAIL} state_t;

  state_t                     state, state_nx;
  logic [COLOR_W*MAX_LEN-1:0] sr, sr_nx, shadow, shadow_nx;
  logic [LEN_W-1:0]           len_q, len_nx, rem, rem_nx, len_clamped;
  logic                       match_q, match_nx, mismatch_q, mismatch_nx;
  logic                       consume;

  assign len_clamped = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sr         <= '0;
      shadow     <= '0;
      len_q      <= '0;
      rem        <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      shadow     <= shadow_nx;
      len_q      <= len_nx;
      rem        <= rem_nx;
      match_q    <= match_nx;
      mismatch_q <= mismatch_nx;
    end
  end

  // Priority: load_p > rewind > guess_valid > next; a wrong guess blocks the consume.
  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    shadow_nx   = shadow;
    len_nx      = len_q;
    rem_nx      = rem;
    match_nx    = 1'b0;
    mismatch_nx = 1'b0;
    consume     = 1'b0;
    if (load_p) begin
      sr_nx     = pattern;
      shadow_nx = pattern;
      len_nx    = len_clamped;
      rem_nx    = len_clamped;
      state_nx  = (len_clamped == '0) ? DONE : ACTIVE;
    end else if (rewind && state != IDLE) begin
      sr_nx    = shadow;
      rem_nx   = len_q;
      state_nx = (len_q == '0) ? DONE : ACTIVE;
    end else if (state == ACTIVE && (guess_valid || next)) begin
      consume = 1'b1;
      if (guess_valid) begin
        if (guess == sr[COLOR_W-1:0]) begin
          match_nx = 1'b1;
        end else begin
          mismatch_nx = 1'b1;
          consume     = 1'b0;
          state_nx    = FAIL;
        end
      end
      if (consume) begin
        sr_nx = sr >> COLOR_W;
        if (rem != '0) rem_nx = rem - LEN_W'(1);
        if (rem <= LEN_W'(1)) state_nx = DONE;
      end
    end
  end

  assign color       = sr[COLOR_W-1:0];
  assign color_valid = (state == ACTIVE);
  assign done        = (state == DONE);
  assign fail        = (state == FAIL);
  assign remaining   = rem;
  assign match       = match_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_simon_pattern_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic checked against a position-indexed reference model.
module tb_simon_pattern_sequencer;
  localparam int CW = 2;
  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ld, rw, nx, gv;
  logic [CW*ML-1:0] pat;
  logic [LW-1:0] len;
  logic [CW-1:0] g;
  logic [CW-1:0] color;
  logic          color_valid, done, fail, match, mismatch;
  logic [LW-1:0] remaining;

  simon_pattern_sequencer #(.COLOR_W(CW), .MAX_LEN(ML)) dut (
    .clk(clk), .resetn(resetn), .load_p(ld), .pattern(pat), .length(len),
    .rewind(rw), .next(nx), .guess_valid(gv), .guess(g),
    .color(color), .color_valid(color_valid), .remaining(remaining),
    .done(done), .fail(fail), .match(match), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the sequence is an array plus a read position.
  logic [CW-1:0] m_ent[ML];
  int  m_pos, m_len;
  bit  m_loaded, m_failed, m_match, m_mis;

  function automatic void model_reset();
    for (int i = 0; i < ML; i++) m_ent[i] = '0;
    m_pos = 0; m_len = 0; m_loaded = 0; m_failed = 0; m_match = 0; m_mis = 0;
  endfunction

  function automatic logic [CW-1:0] m_color();
    return (m_pos < ML) ? m_ent[m_pos] : '0;
  endfunction

  function automatic bit m_active();
    return m_loaded && !m_failed && m_pos < m_len;
  endfunction

  function automatic void model_step(logic l, logic [CW*ML-1:0] p, logic [LW-1:0] n,
                                     logic r, logic x, logic v, logic [CW-1:0] gg);
    m_match = 0; m_mis = 0;
    if (l) begin
      for (int i = 0; i < ML; i++) m_ent[i] = p[i*CW +: CW];
      m_len = (int'(n) > ML) ? ML : int'(n);
      m_pos = 0; m_loaded = 1; m_failed = 0;
    end else if (r && m_loaded) begin
      m_pos = 0; m_failed = 0;
    end else if ((v || x) && m_active()) begin
      if (v && gg != m_color()) begin
        m_mis = 1; m_failed = 1;
      end else begin
        m_match = v;
        m_pos++;
      end
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(logic l, logic [CW*ML-1:0] p, logic [LW-1:0] n,
                       logic r, logic x, logic v, logic [CW-1:0] gg);
    ld = l; pat = p; len = n; rw = r; nx = x; gv = v; g = gg;
    model_step(l, p, n, r, x, v, gg);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".color"},       32'(color),       32'(m_color()));
    chk({tag, ".remaining"},   32'(remaining),   32'(m_len - m_pos));
    chk({tag, ".color_valid"}, 32'(color_valid), 32'(m_active()));
    chk({tag, ".done"},        32'(done),        32'(m_loaded && !m_failed && m_pos == m_len));
    chk({tag, ".fail"},        32'(fail),        32'(m_failed));
    chk({tag, ".match"},       32'(match),       32'(m_match));
    chk({tag, ".mismatch"},    32'(mismatch),    32'(m_mis));
  endtask

  typedef struct {
    logic          l, r, x, v;
    logic [15:0]   p;
    logic [3:0]    n;
    logic [1:0]    gg;
    logic [1:0]    e_col;
    logic [3:0]    e_rem;
    logic          e_cv, e_done, e_fail, e_m, e_mm;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic l, logic [15:0] p, logic [3:0] n, logic r, logic x,
                              logic v, logic [1:0] gg, logic [1:0] ec, logic [3:0] er,
                              logic ecv, logic ed, logic ef, logic em, logic emm);
    vec_t t;
    t.l = l; t.p = p; t.n = n; t.r = r; t.x = x; t.v = v; t.gg = gg;
    t.e_col = ec; t.e_rem = er; t.e_cv = ecv; t.e_done = ed; t.e_fail = ef;
    t.e_m = em; t.e_mm = emm;
    return t;
  endfunction

  initial begin
    //           ld  pat       len rw nx gv g  | col rem cv dn fl m  mm
    vt.push_back(mk(1, 16'h00E4, 4, 0, 0, 0, 0,   0,  4, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0,   1,  3, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0,   2,  2, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0,   3,  1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0,   0,  0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0,   0,  0, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 16'h00E4, 4, 0, 0, 0, 0,   0,  4, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   1,  3, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 1,   2,  2, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3,   2,  2, 0, 0, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 2,   2,  2, 0, 0, 1, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0,   0,  4, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 0,   1,  3, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 1,   2,  2, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 2,   3,  1, 1, 0, 0, 1, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3,   0,  0, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 16'h0003, 0, 0, 0, 0, 0,   3,  0, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 16'h00E4, 4, 0, 1, 1, 3,   0,  4, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 2,   0,  4, 0, 0, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0,   0,  4, 0, 0, 1, 0, 0));
    vt.push_back(mk(1, 16'h00E4, 4, 0, 0, 0, 0,   0,  4, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0,   1,  3, 1, 0, 0, 1, 0));

    ld = 0; pat = '0; len = '0; rw = 0; nx = 0; gv = 0; g = '0;
    resetn = 0;
    model_reset();
    #12;
    check_model("reset");
    @(posedge clk); #1;
    resetn = 1;

    foreach (vt[k]) begin
      apply(vt[k].l, vt[k].p, vt[k].n, vt[k].r, vt[k].x, vt[k].v, vt[k].gg);
      chk($sformatf("vec%0d.color", k),       32'(color),       32'(vt[k].e_col));
      chk($sformatf("vec%0d.remaining", k),   32'(remaining),   32'(vt[k].e_rem));
      chk($sformatf("vec%0d.color_valid", k), 32'(color_valid), 32'(vt[k].e_cv));
      chk($sformatf("vec%0d.done", k),        32'(done),        32'(vt[k].e_done));
      chk($sformatf("vec%0d.fail", k),        32'(fail),        32'(vt[k].e_fail));
      chk($sformatf("vec%0d.match", k),       32'(match),       32'(vt[k].e_m));
      chk($sformatf("vec%0d.mismatch", k),    32'(mismatch),    32'(vt[k].e_mm));
    end

    // Length above MAX_LEN clamps; the ninth step must be ignored.
    apply(1, 16'hB1D8, 4'd15, 0, 0, 0, 0);
    chk("clamp.remaining", 32'(remaining), 32'd8);
    check_model("clamp.load");
    for (int i = 0; i < 9; i++) begin
      apply(0, '0, '0, 0, 1, 0, 0);
      check_model($sformatf("clamp.step%0d", i));
    end
    chk("clamp.done", 32'(done), 32'd1);
    chk("clamp.rem0", 32'(remaining), 32'd0);
    chk("clamp.color0", 32'(color), 32'd0);

    // Asynchronous reset mid-sequence, then a next that must be ignored.
    apply(1, 16'h00E4, 4'd4, 0, 0, 0, 0);
    apply(0, '0, '0, 0, 0, 1, 0);
    #2;
    resetn = 0;
    model_reset();
    #1;
    check_model("async_rst");
    @(posedge clk); #1;
    resetn = 1;
    apply(0, '0, '0, 0, 1, 0, 0);
    check_model("idle_next");
    apply(0, '0, '0, 1, 0, 1, 0);
    check_model("idle_rewind");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic l, r, x, v;
      logic [CW*ML-1:0] p;
      logic [LW-1:0] n;
      logic [CW-1:0] gg;
      l  = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 14) == 0);
      x  = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 2) == 0);
      p  = CW*ML'($urandom);
      n  = LW'($urandom_range(0, 15));
      gg = ($urandom_range(0, 3) != 0) ? m_color() : CW'($urandom);
      apply(l, p, n, r, x, v, gg);
      check_model($sformatf("rand%0d", i));
    end

    ld = 0; rw = 0; nx = 0; gv = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
